// File: rtl/timer_sequencer.sv
// -----------------------------------------------------------------------------
// timer_sequencer
//
// Upstream controller for a single timer. Requested intervals are queued in a
// small FIFO and issued one at a time through a registered start/count pair.
// After each issue the sequencer waits for the timer's done and emits a
// one-cycle expiry pulse carrying a wrapping sequence tag. When the FIFO still
// holds work at that moment, the next interval is issued with no idle gap.
// An abort flushes the queue and forces the timer to zero with a start/0 pulse.
//
// Optional feature (macro TIMER_SEQUENCER_RELOAD_EN):
//   adds reload_i and a register holding the last issued interval. When a
//   timer completes with an empty FIFO and reload_i=1, that interval is
//   reissued. Queued entries always take precedence over a reload.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   req_valid_i   interval request valid
//   req_ready_o   FIFO not full (request accepted on valid && ready)
//   req_count_i   interval length in cycles
//   abort_i       flush the queue and stop the timer
//   start_o       timer start (registered)
//   count_o       timer count (registered, holds while start_o=0)
//   done_i        timer done, only observed while waiting
//   reload_i      (TIMER_SEQUENCER_RELOAD_EN only) reissue last interval
//   expire_o      one-cycle pulse when an interval completes
//   expire_tag_o  tag of the completed interval, valid with expire_o
//   aborted_o     one-cycle pulse when an abort takes effect
//   busy_o        FSM not idle or FIFO non-empty
//   level_o       FIFO occupancy
// -----------------------------------------------------------------------------
module timer_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [WIDTH-1:0]       req_count_i,
  input  logic                   abort_i,
  output logic                   start_o,
  output logic [WIDTH-1:0]       count_o,
  input  logic                   done_i,
`ifdef TIMER_SEQUENCER_RELOAD_EN
  input  logic                   reload_i,
`endif
  output logic                   expire_o,
  output logic [TAG_W-1:0]       expire_tag_o,
  output logic                   aborted_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               expire_q, expire_d;
  logic [TAG_W-1:0]   expire_tag_q, expire_tag_d;
  logic               aborted_q, aborted_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
`ifdef TIMER_SEQUENCER_RELOAD_EN
  logic [WIDTH-1:0]   last_q, last_d;
`endif

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     level_q, level_d;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [WIDTH-1:0]   head;

  assign fifo_empty  = (level_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign req_ready_o = (level_q != FULL_LVL);
  // A push that coincides with an abort is dropped along with the flush.
  assign push        = req_valid_i && req_ready_o && !abort_i;

  // ---------------------------------------------------------------------------
  // FSM next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d      = state_q;
    start_d      = 1'b0;
    count_d      = count_q;
    expire_d     = 1'b0;
    expire_tag_d = expire_tag_q;
    aborted_d    = 1'b0;
    tag_d        = tag_q;
    pop          = 1'b0;
`ifdef TIMER_SEQUENCER_RELOAD_EN
    last_d       = last_q;
`endif

    if (abort_i) begin
      // Abort wins over everything, including a done arriving this cycle.
      state_d   = STOP;
      start_d   = 1'b1;
      count_d   = '0;
      aborted_d = 1'b1;
`ifdef TIMER_SEQUENCER_RELOAD_EN
      last_d    = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            start_d = 1'b1;
            count_d = head;
            state_d = START;
`ifdef TIMER_SEQUENCER_RELOAD_EN
            last_d  = head;
`endif
          end
        end
        START: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (done_i) begin
            expire_d     = 1'b1;
            expire_tag_d = tag_q;
            tag_d        = tag_q + TAG_ONE;
            if (!fifo_empty) begin
              // Back-to-back issue: no IDLE cycle between intervals.
              pop     = 1'b1;
              start_d = 1'b1;
              count_d = head;
              state_d = START;
`ifdef TIMER_SEQUENCER_RELOAD_EN
              last_d  = head;
`endif
            end
`ifdef TIMER_SEQUENCER_RELOAD_EN
            else if (reload_i) begin
              start_d = 1'b1;
              count_d = last_q;
              state_d = START;
            end
`endif
            else begin
              state_d = IDLE;
            end
          end
        end
        STOP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push && pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (!rst_ni) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      count_q      <= '0;
      expire_q     <= 1'b0;
      expire_tag_q <= '0;
      aborted_q    <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
`ifdef TIMER_SEQUENCER_RELOAD_EN
      last_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      count_q      <= count_d;
      expire_q     <= expire_d;
      expire_tag_q <= expire_tag_d;
      aborted_q    <= aborted_d;
      tag_q        <= tag_d;
`ifdef TIMER_SEQUENCER_RELOAD_EN
      last_q       <= last_d;
`endif
      if (abort_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        level_q <= level_d;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_count_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_o      = start_q;
  assign count_o      = count_q;
  assign expire_o     = expire_q;
  assign expire_tag_o = expire_tag_q;
  assign aborted_o    = aborted_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;
  assign level_o      = level_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timer_sequencer
//
// Drives timer_sequencer together with a behavioural timer and compares every
// output, every cycle, against a timeline model: each accepted interval k
// starts at max(arrival_k + 1, start_{k-1} + N_{k-1} + 2) and expires
// N_k + 2 cycles after its start; an abort cancels everything pending and the
// tag counter advances once per expiry. Directed phases are followed by a
// randomized phase that also injects stray done pulses outside the wait window.
// -----------------------------------------------------------------------------
module tb_timer_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TAG_M = 1 << TAG_W;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_count_i;
  logic             abort_i;
  logic             start_o;
  logic [WIDTH-1:0] count_o;
  logic             done_i;
  logic             expire_o;
  logic [TAG_W-1:0] expire_tag_o;
  logic             aborted_o;
  logic             busy_o;
  logic [2:0]       level_o;

  always #5 clk_i = ~clk_i;

  timer_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_count_i  (req_count_i),
    .abort_i      (abort_i),
    .start_o      (start_o),
    .count_o      (count_o),
    .done_i       (done_i),
`ifdef TIMER_SEQUENCER_RELOAD_EN
    .reload_i     (1'b0),
`endif
    .expire_o     (expire_o),
    .expire_tag_o (expire_tag_o),
    .aborted_o    (aborted_o),
    .busy_o       (busy_o),
    .level_o      (level_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct { int arrive; int n; } queued_t;
  typedef struct { int s; int n; }      issued_t;

  queued_t    mq[$];     // accepted, not yet started
  issued_t    mi[$];     // started, not yet expired
  int         free_c;    // earliest cycle the next start may occur
  int         tag_cnt;
  logic [7:0] m_count;
  int         m_tag;

  // Behavioural timer: loads on a start edge, done when it reaches zero.
  int         t_rem;
  bit         t_arm;
  bit         t_done;

  int         cyc;
  int         n_vec;
  int         n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %0d required %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_window(int c, int lo_off);
    foreach (mi[i]) begin
      if (mi[i].s + lo_off <= c && c <= mi[i].s + mi[i].n + 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs, advance timer and model, compare outputs.
  task automatic step(input bit v, input int cnt, input bit ab, input bit rs, input bit spur);
    bit         acc;
    bit         pre_start;
    logic [7:0] pre_count;
    bit         e_exp;
    bit         e_abt;
    bit         e_start;
    int         c;

    rst_ni      = ~rs;
    req_valid_i = v;
    req_count_i = 8'(cnt);
    abort_i     = ab;
    // Stray done pulses are only injected where the sequencer must ignore them.
    done_i      = t_done | (spur & ~in_window(cyc, 1));
    acc         = v && !ab && !rs && (mq.size() < DEPTH);
    pre_start   = start_o;
    pre_count   = count_o;

    @(posedge clk_i);
    #1;
    cyc++;
    c = cyc;

    if (rs) begin
      t_arm = 1'b0;
    end else if (pre_start === 1'b1) begin
      t_rem = int'(pre_count);
      t_arm = 1'b1;
    end else if (t_arm) begin
      if (t_rem == 0) t_arm = 1'b0;
      else            t_rem--;
    end
    t_done = t_arm && (t_rem == 0);

    e_exp   = 1'b0;
    e_abt   = 1'b0;
    e_start = 1'b0;
    if (rs) begin
      mq.delete();
      mi.delete();
      free_c  = 0;
      tag_cnt = 0;
      m_count = '0;
      m_tag   = 0;
    end else if (ab) begin
      mq.delete();
      mi.delete();
      free_c  = c + 1;
      m_count = '0;
      e_start = 1'b1;
      e_abt   = 1'b1;
    end else begin
      if (mi.size() > 0 && mi[0].s + mi[0].n + 2 == c) begin
        e_exp   = 1'b1;
        m_tag   = tag_cnt;
        tag_cnt = (tag_cnt + 1) % TAG_M;
        void'(mi.pop_front());
      end
      if (mq.size() > 0 && mq[0].arrive + 1 <= c && free_c <= c) begin
        e_start = 1'b1;
        m_count = 8'(mq[0].n);
        mi.push_back('{s: c, n: mq[0].n});
        free_c  = c + mq[0].n + 2;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back('{arrive: c, n: cnt});
    end

    check("req_ready", 32'(req_ready_o), 32'(mq.size() < DEPTH));
    check("level",     32'(level_o),     32'(mq.size()));
    check("busy",      32'(busy_o),      32'(mq.size() > 0 || in_window(c, 0) || e_abt));
    check("start",     32'(start_o),     32'(e_start));
    check("count",     32'(count_o),     32'(m_count));
    check("expire",    32'(expire_o),    32'(e_exp));
    check("aborted",   32'(aborted_o),   32'(e_abt));
    if (e_exp || rs) check("expire_tag", 32'(expire_tag_o), 32'(m_tag));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    free_c = 0; tag_cnt = 0; m_count = '0; m_tag = 0;
    t_rem = 0; t_arm = 1'b0; t_done = 1'b0;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_count_i = '0; abort_i = 1'b0; done_i = 1'b0;

    // Reset values.
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Single interval of 5.
    step(1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(12);

    // Back-to-back 3, 0, 7.
    step(1'b1, 3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0, 1'b0);
    idle(22);

    // Long interval, then fill the FIFO and hold valid while full.
    step(1'b1, 20, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2, 1'b0, 1'b0, 1'b0);
    idle(60);

    // Abort in WAIT with two entries queued, then a fresh push.
    step(1'b1, 10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0, 1'b0);
    idle(12);
    // Abort while idle and empty still passes through STOP.
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Seventeen single intervals exercise the tag wrap.
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1, 1'b0, 1'b0, 1'b0);
      idle(4);
    end

    // Reset in the middle of WAIT.
    step(1'b1, 15, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 4, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Randomized traffic with occasional aborts, resets and stray done pulses.
    for (int i = 0; i < 1500; i++) begin
      bit v, ab, rs, sp;
      int cnt;
      v   = ($urandom_range(0, 99) < 40);
      cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 6));
      ab  = ($urandom_range(0, 99) < 2);
      rs  = ($urandom_range(0, 999) < 4);
      sp  = ($urandom_range(0, 99) < 10);
      step(v, cnt, ab, rs, sp);
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Upstream controller for a single `timer` instance. It buffers a queue of requested intervals, issues them to the timer one at a time through a start/count pair, and waits for `done` before issuing the next one. Each completed interval produces a one-cycle expiry pulse with a sequence tag. This lets software-side logic schedule back-to-back delays without babysitting the timer.

Parameters:
WIDTH, 8, interval width; must equal the WIDTH of the driven timer
DEPTH, 4, interval FIFO entries; power of two, ≥2
TAG_W, 4, width of the wrapping sequence tag

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  1  interval request valid
req_ready_o  out  1  FIFO not full; a request is accepted when valid && ready
req_count_i  in  WIDTH  interval length in cycles
abort_i  in  1  flush the queue and stop the timer
start_o  out  WIDTH-less 1  drives timer start_i; registered
count_o  out  WIDTH  drives timer count_i; registered
done_i  in  1  timer done_o
expire_o  out  1  one-cycle pulse when an interval completes
expire_tag_o  out  TAG_W  tag of the completed interval; valid with expire_o
aborted_o  out  1  one-cycle pulse when an abort takes effect
busy_o  out  1  state != IDLE or FIFO non-empty
level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_ni low at an edge): FIFO empty, state IDLE, tag counter 0. Output values after reset:
  - start_o=0, count_o=0, expire_o=0, expire_tag_o=0, aborted_o=0
  - req_ready_o=1, busy_o=0, level_o=0
- Reset mid-operation discards everything; the timer shares the reset, so no timer stop is issued.
- FIFO:
  - Push on req_valid_i && req_ready_o.
  - Pop only by the FSM.
  - Simultaneous push and pop when full is not possible, because ready is deasserted when full.
  - Push and pop in the same cycle leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, STOP.
  - IDLE:
    - If FIFO non-empty: pop the head, count_o<=head, start_o<=1, next state START.
  - START:
    - start_o is high for exactly this one cycle; the timer loads on this edge.
    - Next state WAIT; start_o<=0.
  - WAIT:
    - done_i is sampled starting from the first WAIT cycle.
    - On done_i=1: expire_o<=1, expire_tag_o<=tag, tag<=tag+1 (wraps at 2^TAG_W).
    - If the FIFO is non-empty in that same cycle, pop and go straight to START (back-to-back issue); otherwise go to IDLE.
  - STOP:
    - start_o is high with count_o=0 for this one cycle, forcing the timer to 0.
    - aborted_o<=1; next state IDLE.
- Latency: if an interval N is popped in IDLE at cycle T, then start_o is high at T+1, done_i rises at T+2+N, and expire_o is high at T+3+N. N=0 gives expire_o at T+3.
- Back-to-back throughput: there are N+2 cycles between consecutive start_o pulses.
- abort_i has priority over every other FSM action:
  - Any state: flush the FIFO (level 0), suppress any expire that same cycle, next state STOP.
  - abort_i while in IDLE with an empty FIFO still passes through STOP; this is harmless.
  - A push in the same cycle as abort_i is dropped.
  - The tag counter is not reset by abort.
- done_i is ignored outside WAIT.
- count_o holds its last value when start_o=0.

Optional Feature:
Macro TIMER_SEQUENCER_RELOAD_EN.
- With the macro: add input reload_i (1 bit) and a register holding the last issued interval.
  - In WAIT, on done_i with an empty FIFO and reload_i=1, the last interval is reissued.
  - This reissue follows the same START path and issues the next tag.
  - FIFO entries always take precedence over reload.
  - Abort clears the reload register to 0.
- Without the macro: the reload_i port and the register do not exist; an empty FIFO returns the FSM to IDLE.

Test Plan:
- Reset, push count 5 at cycle T (popped T+1) → start_o/count_o=5 at T+2; expire_o at T+9 with tag 0; busy_o low at T+10.
- Push 3, 0 and 7 back-to-back → three expires with tags 0,1,2. Spacing is 0+2 cycles between the 2nd and 1st, and 7+2 cycles between the 3rd and 2nd; no IDLE cycles between intervals.
- Fill to DEPTH=4 while the first interval (count 20) is running → req_ready_o=0 at level 4. A held valid is accepted after the next pop; level_o never exceeds 4.
- abort_i in WAIT with 2 queued → next cycle start_o=1 and count_o=0, aborted_o pulse, level_o=0. No expire_o for the aborted interval; the next push gets the following tag.
- 17 single intervals with TAG_W=4 → tags go 0..15 then 0; rst_ni low mid-WAIT → all outputs return to reset values on the next cycle.
- RELOAD_EN, reload_i=1, push a single 4 → expires repeat every 6 cycles with incrementing tags. A push of 2 mid-run is issued next, then reload repeats 2.
